// File: rtl/axis_rr_packet_arbiter.sv
// Packet-granular round-robin arbiter: NUM_PORTS AXI-Stream sources share one registered sink.
// A granted source owns the output until it delivers its tlast beat.
module axis_rr_packet_arbiter #(
  parameter  int AXIS_TDATA_WIDTH = 8,
  parameter  int NUM_PORTS        = 4,
  localparam int GRANT_WIDTH      = $clog2(NUM_PORTS)
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [NUM_PORTS-1:0]                  i_s_axis_tvalid,
  output logic [NUM_PORTS-1:0]                  o_s_axis_tready,
  input  logic [NUM_PORTS*AXIS_TDATA_WIDTH-1:0] i_s_axis_tdata,
  input  logic [NUM_PORTS-1:0]                  i_s_axis_tlast,
  input  logic [NUM_PORTS-1:0]                  i_s_axis_tkeep,
  output logic                                  o_m_axis_tvalid,
  input  logic                                  i_m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]           o_m_axis_tdata,
  output logic                                  o_m_axis_tlast,
  output logic                                  o_m_axis_tkeep,
  output logic [GRANT_WIDTH-1:0]                o_grant,
  output logic                                  o_busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                      state, state_next;
  logic [GRANT_WIDTH-1:0]      grant, arb_idx;
  logic                        arb_found;
  logic                        out_free, accept;
  logic [NUM_PORTS-1:0]        s_tready;
  logic [AXIS_TDATA_WIDTH-1:0] sel_data;
  logic                        sel_last, sel_keep;

  assign out_free = !o_m_axis_tvalid || i_m_axis_tready;

  // NOTE: every always_comb output gets a default before any branch, so no path leaves it unassigned (no latch).
  always_comb begin
    s_tready = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      s_tready[i] = (state == BUSY) && (grant == GRANT_WIDTH'(i)) && out_free && !i_rst;
  end

  assign o_s_axis_tready = s_tready;
  assign accept          = |(s_tready & i_s_axis_tvalid);

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    sel_keep = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant == GRANT_WIDTH'(i)) begin
        sel_data = i_s_axis_tdata[i*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH];
        sel_last = i_s_axis_tlast[i];
        sel_keep = i_s_axis_tkeep[i];
      end
    end
  end

  // Search starts just after the last grant; explicit modulo keeps non-power-of-two counts in range.
  always_comb begin
    int cand;
    cand      = 0;
    arb_found = 1'b0;
    arb_idx   = grant;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = (int'(grant) + k) % NUM_PORTS;
      if (!arb_found && i_s_axis_tvalid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = GRANT_WIDTH'(cand);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (arb_found) state_next = BUSY;
      BUSY:    if (accept && sel_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= IDLE;
      grant           <= GRANT_WIDTH'(NUM_PORTS - 1);
      o_m_axis_tvalid <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && arb_found)
        grant <= arb_idx;
      if (accept)
        o_m_axis_tvalid <= 1'b1;
      else if (i_m_axis_tready)
        o_m_axis_tvalid <= 1'b0;
    end
  end

  // NOTE: the payload register has no reset; it is only meaningful while o_m_axis_tvalid is high.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      o_m_axis_tdata <= sel_data;
      o_m_axis_tlast <= sel_last;
      o_m_axis_tkeep <= sel_keep;
    end
  end

  assign o_grant = grant;
  assign o_busy  = (state == BUSY);

endmodule
